// File: rtl/jvm_decode_sequencer_if.sv
// Handshake bundle between the bytecode sequencer and its neighbours.
// The sequencer uses the master modport; the surrounding environment uses slave.
interface jvm_decode_sequencer_if #(
  parameter int ADRW = 8,
  parameter int PCW  = 3
);
  logic [7:0]      ib_data;
  logic            ib_valid;
  logic            ib_ready;
  logic [PCW-1:0]  pcount;
  logic [7:0]      opcode;
  logic            is_wide;
  logic [7:0]      pb_data;
  logic            pb_valid;
  logic            pb_last;
  logic            pb_ready;
  logic [ADRW-1:0] uadr;
  logic            uadr_valid;
  logic            uadr_ready;
  logic [ADRW-1:0] next_uadr;
  logic            busy;
  logic            perr;
  logic [31:0]     icount;

  modport master (
    input  ib_data, ib_valid, pcount, pb_ready, uadr_ready, next_uadr,
    output ib_ready, opcode, is_wide, pb_data, pb_valid, pb_last,
           uadr, uadr_valid, busy, perr, icount
  );

  modport slave (
    output ib_data, ib_valid, pcount, pb_ready, uadr_ready, next_uadr,
    input  ib_ready, opcode, is_wide, pb_data, pb_valid, pb_last,
           uadr, uadr_valid, busy, perr, icount
  );
endinterface

// File: rtl/jvm_decode_sequencer.sv
// JVM bytecode fetch/decode sequencer: strips NOP/WIDE, forwards operands, walks microcode chain.
// Optional macro DECODE_ICOUNT_EN builds the completed-instruction counter on icount.
module jvm_decode_sequencer #(
  parameter int         ADRW    = 8,
  parameter int         PCW     = 3,
  parameter int         MAXP    = 4,
  parameter logic [7:0] WIDE_OP = 8'hC4,
  parameter logic [7:0] NOP_OP  = 8'h00
) (
  input logic clk,
  input logic reset,
  jvm_decode_sequencer_if.master bus
);
  localparam int CW = $clog2(MAXP + 1);

  typedef enum logic [1:0] {FETCH, DECODE, PARAMS, ITER} state_t;

  state_t          state;
  logic            alive;
  logic            wide_pending;
  logic [7:0]      opcode_q;
  logic            is_wide_q;
  logic [7:0]      pb_data_q;
  logic            pb_valid_q;
  logic            pb_last_q;
  logic [ADRW-1:0] uadr_q;
  logic            uadr_valid_q;
  logic            perr_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   neff;

  logic            ib_ready_c;
  logic            ib_hs;
  logic [PCW:0]    neff_raw;
  logic            clamp;
  logic [CW-1:0]   neff_next;

  // In PARAMS the single operand slot may refill in the same cycle it drains,
  // but never beyond the effective operand count.
  always_comb begin
    ib_ready_c = 1'b0;
    case (state)
      FETCH:   ib_ready_c = alive;
      PARAMS:  ib_ready_c = (cnt != neff) && (!pb_valid_q || bus.pb_ready);
      default: ib_ready_c = 1'b0;
    endcase
  end

  assign ib_hs     = bus.ib_valid & ib_ready_c;
  assign neff_raw  = {1'b0, bus.pcount} << is_wide_q;
  assign clamp     = 32'(neff_raw) > 32'(MAXP);
  assign neff_next = clamp ? CW'(MAXP) : CW'(neff_raw);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      alive        <= 1'b0;
      wide_pending <= 1'b0;
      opcode_q     <= '0;
      is_wide_q    <= 1'b0;
      pb_data_q    <= '0;
      pb_valid_q   <= 1'b0;
      pb_last_q    <= 1'b0;
      uadr_q       <= '0;
      uadr_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      cnt          <= '0;
      neff         <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        FETCH: begin
          if (ib_hs) begin
            if (bus.ib_data == NOP_OP) begin
              wide_pending <= 1'b0;
            end else if (bus.ib_data == WIDE_OP) begin
              wide_pending <= 1'b1;
            end else begin
              opcode_q     <= bus.ib_data;
              is_wide_q    <= wide_pending;
              wide_pending <= 1'b0;
              state        <= DECODE;
            end
          end
        end
        DECODE: begin
          neff <= neff_next;
          cnt  <= '0;
          if (clamp) perr_q <= 1'b1;
          if (neff_next == '0) begin
            uadr_q       <= ADRW'(opcode_q);
            uadr_valid_q <= 1'b1;
            state        <= ITER;
          end else begin
            state <= PARAMS;
          end
        end
        PARAMS: begin
          if (pb_valid_q && bus.pb_ready && pb_last_q) begin
            pb_valid_q   <= 1'b0;
            pb_last_q    <= 1'b0;
            uadr_q       <= ADRW'(opcode_q);
            uadr_valid_q <= 1'b1;
            state        <= ITER;
          end else if (ib_hs) begin
            pb_data_q  <= bus.ib_data;
            pb_valid_q <= 1'b1;
            cnt        <= cnt + CW'(1);
            pb_last_q  <= (cnt + CW'(1)) == neff;
          end else if (bus.pb_ready) begin
            pb_valid_q <= 1'b0;
          end
        end
        ITER: begin
          if (bus.uadr_ready) begin
            if (bus.next_uadr != '0) begin
              uadr_q <= bus.next_uadr;
            end else begin
              uadr_valid_q <= 1'b0;
              is_wide_q    <= 1'b0;
              state        <= FETCH;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef DECODE_ICOUNT_EN
  logic [31:0] icount_q;
  logic        icount_inc;

  // NOPs and chain ends each retire one instruction; WIDE prefixes do not.
  assign icount_inc = (state == FETCH && ib_hs && bus.ib_data == NOP_OP) ||
                      (state == ITER && uadr_valid_q && bus.uadr_ready && bus.next_uadr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount_q <= '0;
    end else if (icount_inc) begin
      icount_q <= icount_q + 32'd1;
    end
  end

  assign bus.icount = icount_q;
`else
  assign bus.icount = '0;
`endif

  assign bus.ib_ready   = ib_ready_c;
  assign bus.opcode     = opcode_q;
  assign bus.is_wide    = is_wide_q;
  assign bus.pb_data    = pb_data_q;
  assign bus.pb_valid   = pb_valid_q;
  assign bus.pb_last    = pb_last_q;
  assign bus.uadr       = uadr_q;
  assign bus.uadr_valid = uadr_valid_q;
  assign bus.busy       = (state != FETCH);
  assign bus.perr       = perr_q;
endmodule

// File: tb/tb_jvm_decode_sequencer.sv
// Directed self-checking bench for jvm_decode_sequencer with small pcount / next-address tables.
module tb_jvm_decode_sequencer;
  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   failed;
  logic [31:0] exp_icount;

  jvm_decode_sequencer_if #(.ADRW(8), .PCW(3)) bus ();

  jvm_decode_sequencer #(
    .ADRW(8), .PCW(3), .MAXP(4), .WIDE_OP(8'hC4), .NOP_OP(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] pcount_of(input logic [7:0] op);
    case (op)
      8'h10:   return 3'd1;
      8'h15:   return 3'd1;
      8'h20:   return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] next_of(input logic [7:0] a);
    case (a)
      8'h60:   return 8'h61;
      8'h10:   return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.pcount    = pcount_of(bus.opcode);
  assign bus.next_uadr = next_of(bus.uadr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v);
    bus.ib_data  = d;
    bus.ib_valid = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic done;
    done = 1'b0;
    applyStimulus(b, 1'b1);
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.ib_ready) done = 1'b1;
      tick();
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("ib_accept", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0; passed = 0; failed = 0;
`ifdef DECODE_ICOUNT_EN
    exp_icount = 32'd7;
`else
    exp_icount = 32'd0;
`endif
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0);
    bus.pb_ready   = 1'b0;
    bus.uadr_ready = 1'b0;
    #12;
    checkOutput("rst_ib_ready", bus.ib_ready, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_uadr_valid", bus.uadr_valid, 0);
    checkOutput("rst_pb_valid", bus.pb_valid, 0);
    checkOutput("rst_perr", bus.perr, 0);
    checkOutput("rst_icount", bus.icount, 0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_rst_ib_ready", bus.ib_ready, 1);

    $display("[TB] NOP, NOP, 60 with two-step chain");
    bus.uadr_ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h60);
    checkOutput("t1_opcode", bus.opcode, 8'h60);
    checkOutput("t1_decode_busy", bus.busy, 1);
    checkOutput("t1_decode_ib_ready", bus.ib_ready, 0);
    checkOutput("t1_decode_uvalid", bus.uadr_valid, 0);
    tick();
    checkOutput("t1_uadr0", bus.uadr, 8'h60);
    checkOutput("t1_uvalid0", bus.uadr_valid, 1);
    tick();
    checkOutput("t1_uadr1", bus.uadr, 8'h61);
    checkOutput("t1_uvalid1", bus.uadr_valid, 1);
    tick();
    checkOutput("t1_uvalid_end", bus.uadr_valid, 0);
    checkOutput("t1_busy_end", bus.busy, 0);

    $display("[TB] one operand with pb_ready and uadr_ready stalls");
    bus.pb_ready   = 1'b0;
    bus.uadr_ready = 1'b0;
    send_byte(8'h10);
    tick();
    checkOutput("t2_params_ib_ready", bus.ib_ready, 1);
    applyStimulus(8'h7F, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0);
    checkOutput("t2_pb_data", bus.pb_data, 8'h7F);
    checkOutput("t2_pb_valid", bus.pb_valid, 1);
    checkOutput("t2_pb_last", bus.pb_last, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("t2_hold_pb_data", bus.pb_data, 8'h7F);
      checkOutput("t2_hold_ib_ready", bus.ib_ready, 0);
    end
    bus.pb_ready = 1'b1;
    tick();
    checkOutput("t2_uadr", bus.uadr, 8'h10);
    checkOutput("t2_uvalid", bus.uadr_valid, 1);
    checkOutput("t2_pb_valid_clr", bus.pb_valid, 0);
    checkOutput("t2_is_wide", bus.is_wide, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t2_uadr_hold", bus.uadr, 8'h10);
    end
    bus.uadr_ready = 1'b1;
    tick();
    checkOutput("t2_uadr_next", bus.uadr, 8'h40);
    tick();
    checkOutput("t2_uvalid_end", bus.uadr_valid, 0);

    $display("[TB] WIDE WIDE 15 doubles operand count");
    send_byte(8'hC4);
    send_byte(8'hC4);
    send_byte(8'h15);
    checkOutput("t3_is_wide", bus.is_wide, 1);
    tick();
    checkOutput("t3_perr", bus.perr, 0);
    send_byte(8'hAA);
    checkOutput("t3_pb0", bus.pb_data, 8'hAA);
    checkOutput("t3_last0", bus.pb_last, 0);
    send_byte(8'hBB);
    checkOutput("t3_pb1", bus.pb_data, 8'hBB);
    checkOutput("t3_last1", bus.pb_last, 1);
    checkOutput("t3_no_overfetch", bus.ib_ready, 0);
    tick();
    checkOutput("t3_uadr", bus.uadr, 8'h15);
    checkOutput("t3_wide_in_iter", bus.is_wide, 1);
    tick();
    checkOutput("t3_wide_clear", bus.is_wide, 0);

    $display("[TB] WIDE with pcount=3 clamps to four operands");
    send_byte(8'hC4);
    send_byte(8'h20);
    checkOutput("t4_is_wide", bus.is_wide, 1);
    tick();
    checkOutput("t4_perr", bus.perr, 1);
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    checkOutput("t4_pb_data", bus.pb_data, 8'h04);
    checkOutput("t4_pb_last", bus.pb_last, 1);
    applyStimulus(8'h05, 1'b1);
    checkOutput("t4_stop_fetch", bus.ib_ready, 0);
    tick();
    checkOutput("t4_uadr", bus.uadr, 8'h20);
    checkOutput("t4_iter_ib_ready", bus.ib_ready, 0);
    tick();
    checkOutput("t4_fetch_ready", bus.ib_ready, 1);
    tick();
    applyStimulus(8'h00, 1'b0);
    checkOutput("t4_next_opcode", bus.opcode, 8'h05);
    checkOutput("t4_next_not_wide", bus.is_wide, 0);
    tick();
    checkOutput("t4_next_uadr", bus.uadr, 8'h05);
    tick();
    checkOutput("t4_perr_sticky", bus.perr, 1);
    checkOutput("t4_icount", bus.icount, exp_icount);

    $display("[TB] asynchronous reset mid-ITER");
    bus.uadr_ready = 1'b0;
    send_byte(8'h60);
    tick();
    checkOutput("t5_iter_uvalid", bus.uadr_valid, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_rst_uvalid", bus.uadr_valid, 0);
    checkOutput("t5_rst_uadr", bus.uadr, 0);
    checkOutput("t5_rst_busy", bus.busy, 0);
    checkOutput("t5_rst_perr", bus.perr, 0);
    checkOutput("t5_rst_icount", bus.icount, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] asynchronous reset mid-PARAMS");
    bus.pb_ready = 1'b0;
    send_byte(8'h10);
    tick();
    applyStimulus(8'h7F, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0);
    checkOutput("t6_pb_valid", bus.pb_valid, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst_pb_valid", bus.pb_valid, 0);
    checkOutput("t6_rst_pb_data", bus.pb_data, 0);
    checkOutput("t6_rst_pb_last", bus.pb_last, 0);
    checkOutput("t6_rst_opcode", bus.opcode, 0);
    checkOutput("t6_rst_ib_ready", bus.ib_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.uadr_ready = 1'b1;
    send_byte(8'h60);
    checkOutput("t6_opcode", bus.opcode, 8'h60);
    checkOutput("t6_busy", bus.busy, 1);
    tick();
    checkOutput("t6_uadr", bus.uadr, 8'h60);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
